// File: rtl/dds_pkg.sv
// Shared constants, waveform mode encodings and the quarter-sine table generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dds_pkg;

   typedef enum logic [1:0] {
      MODE_SINE = 2'd0,
      MODE_TRI  = 2'd1,
      MODE_SQR  = 2'd2,
      MODE_SAW  = 2'd3
   } mode_e;

   localparam int DDS_OUT_W    = 8;
   localparam int DDS_PHASE_W  = 16;
   localparam int DDS_LUT_AW   = 6;
   localparam int DDS_CONV_DIV = 8;

   // Fixed-point scale for the elaboration-time sine series (2^28).
   localparam int     SIN_FRAC = 28;
   localparam longint PI_FX    = 64'sd843314857;   // round(pi * 2^28)

   // Q[k] = round(M + (M-1)*sin(pi*k/2^(aw+1))), M = 2^(out_w-1).
   // Evaluated as a Taylor series in 64-bit fixed point so the table can be
   // built as constants without relying on real-valued system functions.
   function automatic int sin_q(input int k, input int aw, input int out_w);
      longint x;
      longint term;
      longint sum;
      longint m;
      longint val;
      x    = (PI_FX * longint'(k)) >>> (aw + 1);
      term = x;
      sum  = x;
      for (int n = 1; n <= 7; n++) begin
         term = (term * x) >>> SIN_FRAC;
         term = (term * x) >>> SIN_FRAC;
         term = -term / longint'((2 * n) * (2 * n + 1));
         sum  = sum + term;
      end
      m   = longint'(1) << (out_w - 1);
      val = (m << SIN_FRAC) + (m - 1) * sum;
      return int'((val + (longint'(1) << (SIN_FRAC - 1))) >>> SIN_FRAC);
   endfunction

endpackage

// File: rtl/sin_quarter_lut.sv
// Quarter-wave sine ROM, 2^LUT_AW+1 entries covering 0..pi/2 inclusive.
// Latency: 1 clk (registered read data).
// Backpressure: none; a new address is accepted every clk.
module sin_quarter_lut
   import dds_pkg::*;
#(
   parameter int LUT_AW = DDS_LUT_AW,
   parameter int OUT_W  = DDS_OUT_W
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [LUT_AW:0]   i_addr,
   output logic [OUT_W-1:0]  o_dat
);

   localparam int DEPTH = (1 << LUT_AW) + 1;

   logic [OUT_W-1:0] w_rom [0:DEPTH-1];
   logic [OUT_W-1:0] r_dat;

   genvar gk;
   generate
      for (gk = 0; gk < DEPTH; gk++) begin : g_rom
         assign w_rom[gk] = OUT_W'(sin_q(gk, LUT_AW, OUT_W));
      end
   endgenerate

   // Registered table read.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_dat <= '0;
      end else begin
         r_dat <= w_rom[i_addr];
      end
   end

   assign o_dat = r_dat;

endmodule

// File: rtl/dds_sin_gen.sv
// DDS waveform generator (sine/triangle/square/saw) ticked by an async sample clock.
// Latency: outputs update 4 clk edges after the edge that first samples sample_clk high.
// Backpressure: none; every enabled tick produces exactly one sample.
module dds_sin_gen
   import dds_pkg::*;
#(
   parameter int OUT_W    = DDS_OUT_W,
   parameter int PHASE_W  = DDS_PHASE_W,
   parameter int LUT_AW   = DDS_LUT_AW,
   parameter int CONV_DIV = DDS_CONV_DIV
)(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_sample_clk,
   input  logic               i_enable,
   input  logic [PHASE_W-1:0] i_phase_inc,
   input  logic [1:0]         i_mode,
   output logic [OUT_W-1:0]   o_out,
   output logic               o_out_valid,
   output logic               o_new_period,
   output logic               o_start_conv,
   output logic               o_phaze
);

   localparam int CNT_W  = (CONV_DIV > 1) ? $clog2(CONV_DIV) : 1;
   localparam int TOP_W  = OUT_W + 1;      // phase bits needed by tri/saw/square
   localparam int LUTA_W = LUT_AW + 2;     // phase bits needed by the sine path
   localparam int KEEP_W = (TOP_W > LUTA_W) ? TOP_W : LUTA_W;
   localparam int AW1    = LUT_AW + 1;

   // Tick detection
   logic r_sync1, r_sync2, r_sync3;
   logic w_tick, w_adv;

   // Generator state
   logic [PHASE_W-1:0] r_acc;
   logic               r_first;
   logic               r_carry;
   logic [CNT_W-1:0]   r_conv_cnt;
   logic [1:0]         r_mode;

   // Tick-stage combinational values
   logic [PHASE_W:0]   w_sum;
   logic               w_np;
   logic [CNT_W-1:0]   w_cnt_eff;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [1:0]         w_mode_sel;

   // Stage 0 (tick captured)
   logic               r_s0_vld, r_s0_np, r_s0_sc;
   logic [1:0]         r_s0_mode;
   logic [KEEP_W-1:0]  r_s0_keep;

   // Stage 1 (LUT read)
   logic               r_s1_vld, r_s1_np, r_s1_sc;
   logic [1:0]         r_s1_mode;
   logic [TOP_W-1:0]   r_s1_top;

   logic [LUT_AW-1:0]  w_idx;
   logic [AW1-1:0]     w_addr;
   logic [OUT_W-1:0]   w_lut;
   logic [OUT_W-1:0]   w_wave;

   assign w_tick = r_sync2 & ~r_sync3;
   assign w_adv  = w_tick & i_enable;

   // Two-flop synchroniser plus a third flop for rising-edge detection.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         r_sync1 <= i_sample_clk;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   // Period start, conversion-counter realignment and mode selection for this tick.
   always_comb begin
      w_sum      = {1'b0, r_acc} + {1'b0, i_phase_inc};
      w_np       = r_first | r_carry;
      w_cnt_eff  = w_np ? '0 : r_conv_cnt;
      w_cnt_nxt  = (w_cnt_eff == CNT_W'(CONV_DIV - 1)) ? '0 : (w_cnt_eff + CNT_W'(1));
      w_mode_sel = w_np ? i_mode : r_mode;
   end

   // Accumulator and per-period state advance only on enabled ticks.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_acc      <= '0;
         r_first    <= 1'b1;
         r_carry    <= 1'b0;
         r_conv_cnt <= '0;
         r_mode     <= MODE_SINE;
      end else if (w_adv) begin
         r_acc      <= w_sum[PHASE_W-1:0];
         r_first    <= 1'b0;
         r_carry    <= w_sum[PHASE_W];
         r_conv_cnt <= w_cnt_nxt;
         r_mode     <= w_mode_sel;
      end
   end

   // Stage 0: capture the pre-increment phase and the flags of this sample.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_s0_vld  <= 1'b0;
         r_s0_np   <= 1'b0;
         r_s0_sc   <= 1'b0;
         r_s0_mode <= MODE_SINE;
         r_s0_keep <= '0;
      end else begin
         r_s0_vld  <= w_adv;
         r_s0_np   <= w_np;
         r_s0_sc   <= (w_cnt_eff == '0);
         r_s0_mode <= w_mode_sel;
         r_s0_keep <= r_acc[PHASE_W-1 -: KEEP_W];
      end
   end

   // Odd quadrants read the table mirrored; index 2^LUT_AW reaches the peak entry.
   assign w_idx  = r_s0_keep[KEEP_W-3 -: LUT_AW];
   assign w_addr = r_s0_keep[KEEP_W-2] ? (AW1'(1 << LUT_AW) - {1'b0, w_idx})
                                       : {1'b0, w_idx};

   sin_quarter_lut #(
      .LUT_AW (LUT_AW),
      .OUT_W  (OUT_W)
   ) u_lut (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_addr (w_addr),
      .o_dat  (w_lut)
   );

   // Stage 1: carry sample flags alongside the registered table read.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_s1_vld  <= 1'b0;
         r_s1_np   <= 1'b0;
         r_s1_sc   <= 1'b0;
         r_s1_mode <= MODE_SINE;
         r_s1_top  <= '0;
      end else begin
         r_s1_vld  <= r_s0_vld;
         r_s1_np   <= r_s0_np;
         r_s1_sc   <= r_s0_sc;
         r_s1_mode <= r_s0_mode;
         r_s1_top  <= r_s0_keep[KEEP_W-1 -: TOP_W];
      end
   end

   // Waveform select; the top stored bit is the phase MSB (second half-period).
   always_comb begin
      w_wave = '0;
      case (mode_e'(r_s1_mode))
         MODE_SINE: w_wave = r_s1_top[TOP_W-1] ? (OUT_W'(0) - w_lut) : w_lut;
         MODE_TRI:  w_wave = r_s1_top[TOP_W-1] ? ~r_s1_top[TOP_W-2:0] : r_s1_top[TOP_W-2:0];
         MODE_SQR:  w_wave = r_s1_top[TOP_W-1] ? OUT_W'(1) : '1;
         MODE_SAW:  w_wave = r_s1_top[TOP_W-1:1];
         default:   w_wave = '0;
      endcase
   end

   // Output register: sample and phase flag hold between ticks, pulses last one clk.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_out        <= OUT_W'(1 << (OUT_W - 1));
         o_out_valid  <= 1'b0;
         o_new_period <= 1'b0;
         o_start_conv <= 1'b0;
         o_phaze      <= 1'b0;
      end else begin
         o_out_valid  <= r_s1_vld;
         o_new_period <= r_s1_vld & r_s1_np;
         o_start_conv <= r_s1_vld & r_s1_sc;
         if (r_s1_vld) begin
            o_out   <= w_wave;
            o_phaze <= ~r_s1_top[TOP_W-1];
         end
      end
   end

endmodule

// File: tb/tb_dds_sin_gen.sv
// Directed bench for dds_sin_gen at default parameters.
// Latency: each sample_clk tick is observed 5 clk edges after it is raised.
// Backpressure: n/a.
module tb_dds_sin_gen;
   import dds_pkg::*;

   logic        clk;
   logic        rst;
   logic        sample_clk;
   logic        enable;
   logic [15:0] phase_inc;
   logic [1:0]  mode;
   logic [7:0]  o_out;
   logic        o_out_valid;
   logic        o_new_period;
   logic        o_start_conv;
   logic        o_phaze;

   int checks = 0;
   int errors = 0;
   int extra;

   logic [7:0] g_out;
   logic       g_vld, g_np, g_sc, g_ph;

   dds_sin_gen dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_sample_clk (sample_clk),
      .i_enable     (enable),
      .i_phase_inc  (phase_inc),
      .i_mode       (mode),
      .o_out        (o_out),
      .o_out_valid  (o_out_valid),
      .o_new_period (o_new_period),
      .o_start_conv (o_start_conv),
      .o_phaze      (o_phaze)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One sample_clk pulse; outputs captured #1 after the 5th edge after the rise.
   task automatic run_tick();
      @(posedge clk);
      #2 sample_clk = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      g_out = o_out;
      g_vld = o_out_valid;
      g_np  = o_new_period;
      g_sc  = o_start_conv;
      g_ph  = o_phaze;
      #1 sample_clk = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      rst        = 1'b0;
      sample_clk = 1'b0;
      enable     = 1'b1;
      phase_inc  = 16'd1024;
      mode       = 2'd0;
      g_out = '0; g_vld = 0; g_np = 0; g_sc = 0; g_ph = 0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out", o_out, 128);
      chk("rst_vld", o_out_valid, 0);
      chk("rst_np", o_new_period, 0);
      chk("rst_sc", o_start_conv, 0);
      chk("rst_ph", o_phaze, 0);
      @(negedge clk) rst = 1'b1;

      // Tick 0 with exact pulse timing
      @(posedge clk);
      #2 sample_clk = 1'b1;
      @(posedge clk);                  // first edge seeing sample_clk high
      repeat (3) @(posedge clk);
      #1 chk("t0_vld_early", o_out_valid, 0);
      @(posedge clk);
      #1;
      chk("t0_vld", o_out_valid, 1);
      chk("t0_out", o_out, 128);
      chk("t0_np", o_new_period, 1);
      chk("t0_sc", o_start_conv, 1);
      chk("t0_ph", o_phaze, 1);
      @(posedge clk);
      #1;
      chk("t0_vld_width", o_out_valid, 0);
      chk("t0_np_width", o_new_period, 0);
      extra = 0;
      repeat (10) begin
         @(posedge clk);
         #1 if (o_out_valid) extra++;
      end
      chk("t0_no_repeat", extra, 0);
      sample_clk = 1'b0;
      repeat (3) @(posedge clk);

      // Ticks 1..232: sine, then square from 64, saw from 128, triangle from 192
      for (int t = 1; t <= 232; t++) begin
         if (t == 20)  mode = 2'd2;
         if (t == 100) mode = 2'd3;
         if (t == 145) mode = 2'd1;
         if (t == 137) begin
            enable = 1'b0;
            for (int d = 0; d < 10; d++) begin
               run_tick();
               chk("dis_vld", g_vld, 0);
               chk("dis_np", g_np, 0);
               chk("dis_sc", g_sc, 0);
               chk("dis_out", g_out, 32);
            end
            enable = 1'b1;
         end
         run_tick();
         chk("vld", g_vld, 1);
         chk("sc_every8", g_sc, (t % 8 == 0));
         chk("np_period", g_np, (t == 64 || t == 128 || t == 192));
         if (t == 16)  chk("sin_t16", g_out, 255);
         if (t == 32)  chk("sin_t32", g_out, 128);
         if (t == 32)  chk("ph_t32", g_ph, 0);
         if (t == 48)  chk("sin_t48", g_out, 1);
         if (t == 63)  chk("sin_t63_latched", g_out, 116);
         if (t == 64)  chk("sqr_t64", g_out, 255);
         if (t == 80)  chk("sqr_t80", g_out, 255);
         if (t == 96)  chk("sqr_t96", g_out, 1);
         if (t == 127) chk("sqr_t127", g_out, 1);
         if (t == 128) chk("saw_t128", g_out, 0);
         if (t == 136) chk("saw_t136", g_out, 32);
         if (t == 137) chk("saw_resume", g_out, 36);
         if (t == 144) chk("saw_t144", g_out, 64);
         if (t == 191) chk("saw_t191", g_out, 252);
         if (t == 192) chk("tri_t192", g_out, 0);
         if (t == 200) chk("tri_t200", g_out, 64);
         if (t == 224) chk("tri_t224", g_out, 255);
         if (t == 224) chk("ph_t224", g_ph, 0);
         if (t == 232) chk("tri_t232", g_out, 191);
      end

      // Reset while a tick is in flight
      mode = 2'd0;
      @(posedge clk);
      #2 sample_clk = 1'b1;
      repeat (3) @(posedge clk);      // tick captured into the pipeline
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_out", o_out, 128);
      chk("mid_rst_vld", o_out_valid, 0);
      chk("mid_rst_np", o_new_period, 0);
      chk("mid_rst_sc", o_start_conv, 0);
      chk("mid_rst_ph", o_phaze, 0);
      repeat (3) @(posedge clk);
      sample_clk = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      extra = 0;
      repeat (8) begin
         @(posedge clk);
         #1 if (o_out_valid) extra++;
      end
      chk("mid_rst_discard", extra, 0);
      run_tick();
      chk("post_rst_vld", g_vld, 1);
      chk("post_rst_out", g_out, 128);
      chk("post_rst_np", g_np, 1);
      chk("post_rst_sc", g_sc, 1);

      // phase_inc = 0: same sample repeats, no new period, conversions continue
      phase_inc = 16'd0;
      for (int k = 1; k <= 8; k++) begin
         run_tick();
         chk("inc0_out", g_out, 140);
         chk("inc0_np", g_np, 0);
         chk("inc0_sc", g_sc, (k == 8));
      end

      // phase_inc = 0xFFFF: phase steps down by one, carry on every add
      phase_inc = 16'hFFFF;
      run_tick();
      chk("dec_t9_out", g_out, 140);
      for (int k = 10; k <= 12; k++) begin
         run_tick();
         chk("dec_np", g_np, 1);
         chk("dec_sc", g_sc, 1);
         chk("dec_out", g_out, 137);
         chk("dec_noX", $isunknown({o_out, o_out_valid, o_new_period, o_start_conv, o_phaze}), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dds_sin_gen.md
DDS_SIN_GEN -- requirements
Module: dds_sin_gen

Interface
REQ-001 Parameter OUT_W, default 8: output sample width, 4..12.
REQ-002 Parameter PHASE_W, default 16: phase accumulator width, at least OUT_W+2.
REQ-003 Parameter LUT_AW, default 6: quarter-wave LUT address width, at most PHASE_W-2.
REQ-004 Parameter CONV_DIV, default 8: samples per start_conv pulse, at least 1.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-007 sample_clk  in  1  asynchronous sample-rate clock; each rising edge is one sample tick.
REQ-008 enable  in  1  1 = ticks advance the generator; 0 = ticks ignored.
REQ-009 phase_inc  in  PHASE_W  phase step per tick, unsigned.
REQ-010 mode  in  2  waveform select: 0 sine, 1 triangle, 2 square, 3 sawtooth.
REQ-011 out  out  OUT_W  unsigned waveform sample, midscale M = 2^(OUT_W-1).
REQ-012 out_valid  out  1  one-clk pulse marking each out update.
REQ-013 new_period  out  1  one-clk pulse with the first sample of each period.
REQ-014 start_conv  out  1  one-clk ADC-start pulse every CONV_DIV samples.
REQ-015 phaze  out  1  1 during the first half-period (phase MSB = 0), 0 during the second.

Function
REQ-016 Tick detection SHALL be a 2-FF synchroniser plus rising-edge detect, giving one tick per sample_clk rising edge.
REQ-017 Ticks with enable=0 SHALL change nothing; out_valid, new_period and start_conv SHALL stay 0.
REQ-018 On each enabled tick, the sample SHALL be computed from the pre-increment accumulator P; then acc = (acc + phase_inc) mod 2^PHASE_W.
REQ-019 out, out_valid, new_period, start_conv and phaze SHALL all update on the same clk edge, exactly 4 clk edges after the edge that first samples sample_clk high.
REQ-020 Sine: A = P[PHASE_W-1 -: LUT_AW+2], with quadrant q = A[top 2 bits] and index i = A[low LUT_AW bits].
REQ-021 Sine quarter table: Q[k] = round(M + (M-1)*sin(pi*k/2^(LUT_AW+1))), k = 0..2^LUT_AW (2^LUT_AW+1 entries).
REQ-022 Sine output by quadrant: q0 Q[i]; q1 Q[2^LUT_AW - i]; q2 2^OUT_W - Q[i]; q3 2^OUT_W - Q[2^LUT_AW - i]. Range is 1..2^OUT_W-1.
REQ-023 Triangle: t = P[PHASE_W-2 -: OUT_W]; out = t when P[MSB]=0, otherwise ~t.
REQ-024 Square: out = 2^OUT_W-1 when P[MSB]=0, otherwise 1.
REQ-025 Sawtooth: out = P[PHASE_W-1 -: OUT_W].
REQ-026 A mode change SHALL take effect only on a new_period sample; the latched active mode is used until then.
REQ-027 new_period SHALL pulse on the first enabled tick after reset and on every tick following an accumulator carry-out.
REQ-028 start_conv SHALL pulse when conv_cnt = 0.
REQ-029 conv_cnt SHALL advance modulo CONV_DIV per enabled tick and be forced so that every new_period sample also has start_conv.
REQ-030 phaze = ~P[PHASE_W-1].
REQ-031 phase_inc = 0: out SHALL repeat the same value each tick; new_period SHALL not recur; start_conv SHALL continue.
REQ-032 A phase_inc change SHALL apply from the next tick's increment without clearing the accumulator.

Reset
REQ-033 With rst=0: out = M, out_valid = new_period = start_conv = phaze = 0.
REQ-034 With rst=0: acc = 0, conv_cnt = 0, active mode = 0 (sine), synchroniser cleared, first-tick flag set.
REQ-035 Reset asserted mid-operation SHALL force the REQ-033/034 values immediately; any tick in flight SHALL be discarded.

Structure
REQ-036 Package dds_pkg SHALL hold the mode encodings and default parameter constants.
REQ-037 The quarter-wave table SHALL be a sub-module sin_quarter_lut (LUT_AW, OUT_W), with a registered output forming pipeline stage 1.

Verification
REQ-038 Defaults, mode 0, phase_inc=1024 (64 ticks/period): samples at ticks 0, 16, 32, 48 -> 128, 255, 128, 1; new_period at ticks 0 and 64; start_conv at ticks 0, 8, 16, ...
REQ-039 Single sample_clk rise -> out_valid exactly 4 clk after the first high sample, one clk wide; no further pulse while sample_clk stays high.
REQ-040 mode changed 0 -> 2 at tick 20 with phase_inc=1024 -> sine continues until tick 64, then out=255 for ticks 64..95 and 1 for ticks 96..127.
REQ-041 enable=0 for 10 ticks mid-period -> out holds and no pulses; the sequence resumes from the same phase.
REQ-042 rst pulled low between tick edge and out update -> out=128 and all flags 0 at once; the first tick after release gives new_period=start_conv=1, out=128.
REQ-043 phase_inc=0xFFFF -> phase decrements by 1 per tick; new_period every tick after the first; no X on any output.
